step_seq_driver: RTL

Parametrised unipolar/bipolar stepper coil sequencer for the Kitchen's helper motor subsystem. It replaces the fixed two-phase, free-running driver with a command-driven one. A controller issues a move with a direction, stepping mode, step count and step period. The block produces the 4-bit coil pattern (A B A' B'), tracks a signed position, and reports completion. One instance drives one motor.

---
 rtl/step_seq_driver.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/step_seq_driver.sv
// Command-driven stepper coil sequencer: wave/full/half stepping, signed position, done/abort reporting.
// Optional macro STEP_HOLD_EN keeps the last coil pattern energised in IDLE instead of releasing it.
module step_seq_driver #(
  parameter int CNT_W = 16,
  parameter int PER_W = 20,
  parameter int POS_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [1:0]              cmd_mode,
  input  logic [CNT_W-1:0]        cmd_steps,
  input  logic [PER_W-1:0]        cmd_period,
  input  logic                    abort,
  output logic [3:0]              coils,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [CNT_W-1:0]        steps_left,
  output logic signed [POS_W-1:0] position,
  output logic [2:0]              phase
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [1:0]       MODE_WAVE = 2'b00;
  localparam logic [1:0]       MODE_HALF = 2'b10;
  localparam logic [PER_W-1:0] PER_ONE   = 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [POS_W-1:0] POS_ONE   = 1;

  state_t                    state_q, state_d;
  logic                      dir_q, dir_d;
  logic [1:0]                mode_q, mode_d;
  logic [PER_W-1:0]          per_q, per_d;
  logic [PER_W-1:0]          timer_q, timer_d;
  logic [2:0]                phase_q, phase_d;
  logic [3:0]                coils_q, coils_d;
  logic signed [POS_W-1:0]   position_q, position_d;
  logic [CNT_W-1:0]          steps_left_q, steps_left_d;
  logic                      done_q, done_d;
  logic                      aborted_q, aborted_d;
  logic [PER_W-1:0]          per_eff;
  logic [2:0]                phase_nxt;

  function automatic logic [3:0] coil_pat(input logic [2:0] idx);
    case (idx)
      3'd0:    coil_pat = 4'b0001;
      3'd1:    coil_pat = 4'b0011;
      3'd2:    coil_pat = 4'b0010;
      3'd3:    coil_pat = 4'b0110;
      3'd4:    coil_pat = 4'b0100;
      3'd5:    coil_pat = 4'b1100;
      3'd6:    coil_pat = 4'b1000;
      default: coil_pat = 4'b1001;
    endcase
  endfunction

  // Full mode lives on odd indices, wave on even: skip one more slot if parity is wrong.
  function automatic logic [2:0] next_phase(input logic [2:0] i, input logic dir,
                                            input logic [1:0] mode);
    logic [2:0] n;
    n = dir ? i + 3'd1 : i - 3'd1;
    if (mode != MODE_HALF && n[0] != (mode != MODE_WAVE))
      n = dir ? n + 3'd1 : n - 3'd1;
    return n;
  endfunction

  assign per_eff   = (cmd_period == '0) ? PER_ONE : cmd_period;
  assign phase_nxt = next_phase(phase_q, dir_q, mode_q);

  // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    mode_d       = mode_q;
    per_d        = per_q;
    timer_d      = timer_q;
    phase_d      = phase_q;
    coils_d      = coils_q;
    position_d   = position_q;
    steps_left_d = steps_left_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;

    case (state_q)
      S_IDLE: begin
`ifndef STEP_HOLD_EN
        if (done_q) coils_d = 4'b0000;
`endif
        if (cmd_valid && cmd_ready) begin
          dir_d        = cmd_dir;
          mode_d       = cmd_mode;
          per_d        = per_eff;
          steps_left_d = cmd_steps;
          aborted_d    = 1'b0;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
            timer_d = per_eff - PER_ONE;
            coils_d = coil_pat(phase_q);
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (timer_q == '0) begin
          phase_d      = phase_nxt;
          coils_d      = coil_pat(phase_nxt);
          position_d   = dir_q ? position_q + POS_ONE : position_q - POS_ONE;
          steps_left_d = steps_left_q - CNT_ONE;
          timer_d      = per_q - PER_ONE;
          if (steps_left_q == CNT_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q - PER_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dir_q        <= 1'b0;
      mode_q       <= 2'b00;
      per_q        <= '0;
      timer_q      <= '0;
      phase_q      <= 3'd0;
      coils_q      <= 4'b0000;
      position_q   <= '0;
      steps_left_q <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      mode_q       <= mode_d;
      per_q        <= per_d;
      timer_q      <= timer_d;
      phase_q      <= phase_d;
      coils_q      <= coils_d;
      position_q   <= position_d;
      steps_left_q <= steps_left_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign cmd_ready  = ~rst && (state_q == S_IDLE);
  assign busy       = (state_q == S_RUN);
  assign coils      = coils_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_left = steps_left_q;
  assign position   = position_q;
  assign phase      = phase_q;

endmodule
